// File: rtl/fifo_data_buffer.sv
// rtl/fifo_data_buffer.sv - byte-to-dibit transmit buffer with packet FIFO and inter-packet gap
// Whole packets are stored as {last, byte} entries, then streamed LSB dibit first.
module fifo_data_buffer #(
    parameter int DEPTH      = 2048,
    parameter int IPG_CYCLES = 48
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    input  logic [7:0] byte_in,
    output logic       axiov,
    output logic [1:0] axiod
);
    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(IPG_CYCLES) + 1;
    // Occupancy limits include the byte waiting in the capture register.
    localparam logic [AW:0]   BODY_LIMIT = (AW + 1)'(DEPTH - 2);
    localparam logic [AW:0]   TERM_LIMIT = (AW + 1)'(DEPTH - 1);
    // The IDLE cycle that issues the first pop also keeps axiov low.
    localparam logic [GW-1:0] GAP_END    = GW'(IPG_CYCLES - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } tx_state_t;

    logic [8:0]    mem [0:DEPTH-1];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ;
    logic [AW:0]   pkt_cnt;
    logic [7:0]    hold_byte;
    logic          pending;

    tx_state_t     state;
    logic [7:0]    cur_byte;
    logic          cur_last;
    logic [1:0]    phase;
    logic [GW-1:0] gap_cnt;

    logic          wr_en;
    logic          commit;
    logic          rd_en;
    logic          done;
    logic [8:0]    rd_data;
    logic [1:0]    dibit;

    always_comb begin
        wr_en   = 1'b0;
        if (pending) begin
            wr_en = valid_in ? (occ < BODY_LIMIT) : (occ < TERM_LIMIT);
        end
        commit  = wr_en && !valid_in;
        rd_en   = ((state == IDLE) && (pkt_cnt != '0)) ||
                  ((state == SEND) && (phase == 2'd3) && !cur_last);
        done    = (state == SEND) && (phase == 2'd3) && cur_last;
        rd_data = mem[rd_ptr];
        dibit   = cur_byte[{phase, 1'b0} +: 2];
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {!valid_in, hold_byte};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            occ       <= '0;
            pkt_cnt   <= '0;
            hold_byte <= '0;
            pending   <= 1'b0;
            state     <= IDLE;
            cur_byte  <= '0;
            cur_last  <= 1'b0;
            phase     <= '0;
            gap_cnt   <= '0;
            axiov     <= 1'b0;
            axiod     <= 2'b00;
        end else begin
            if (valid_in) begin
                hold_byte <= byte_in;
                pending   <= 1'b1;
            end else begin
                pending   <= 1'b0;
            end

            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            occ     <= occ + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);
            pkt_cnt <= pkt_cnt + (AW + 1)'(commit) - (AW + 1)'(done);

            case (state)
                IDLE: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    if (pkt_cnt != '0) begin
                        cur_byte <= rd_data[7:0];
                        cur_last <= rd_data[8];
                        phase    <= '0;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    axiov <= 1'b1;
                    axiod <= dibit;
                    phase <= phase + 1'b1;
                    if (phase == 2'd3) begin
                        if (cur_last) begin
                            gap_cnt <= '0;
                            state   <= GAP;
                        end else begin
                            cur_byte <= rd_data[7:0];
                            cur_last <= rd_data[8];
                        end
                    end
                end
                GAP: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    if (gap_cnt == GAP_END) begin
                        state <= IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: begin
                    axiov <= 1'b0;
                    axiod <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_data_buffer.sv
// tb/tb_fifo_data_buffer.sv - directed and randomized bench for fifo_data_buffer
// Output packets are rebuilt from dibits and compared against the input packets.
module tb_fifo_data_buffer;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid_in0, valid_in1;
    logic [7:0] byte_in0, byte_in1;
    logic       axiov0, axiov1;
    logic [1:0] axiod0, axiod1;

    always #5 clk = ~clk;

    fifo_data_buffer #(.DEPTH(2048), .IPG_CYCLES(48)) dut0 (
        .clk(clk), .rst(rst), .valid_in(valid_in0), .byte_in(byte_in0),
        .axiov(axiov0), .axiod(axiod0)
    );

    fifo_data_buffer #(.DEPTH(8), .IPG_CYCLES(48)) dut1 (
        .clk(clk), .rst(rst), .valid_in(valid_in1), .byte_in(byte_in1),
        .axiov(axiov1), .axiod(axiod1)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [1:0] dq0[$], dq1[$];
    int plen0[$], plen1[$], rise_q0[$], rise_q1[$], gap_q0[$], gap_q1[$];
    int cur_len0 = 0, cur_len1 = 0, low_run0 = 0, low_run1 = 0;
    int rises0 = 0, rises1 = 0, bad_idle0 = 0, bad_idle1 = 0;
    bit in_pkt0 = 0, in_pkt1 = 0;

    logic [7:0] tx_q[$];
    logic [7:0] exp_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < cur_len0; i++) dq0.delete(dq0.size() - 1);
            if (in_pkt0) begin
                rise_q0.delete(rise_q0.size() - 1);
                gap_q0.delete(gap_q0.size() - 1);
            end
            cur_len0 = 0; in_pkt0 = 0; low_run0 = 0;
        end else if (axiov0) begin
            if (!in_pkt0) begin
                in_pkt0 = 1; rises0++;
                rise_q0.push_back(cyc); gap_q0.push_back(low_run0);
            end
            dq0.push_back(axiod0); cur_len0++;
        end else begin
            if (axiod0 !== 2'b00) bad_idle0++;
            if (in_pkt0) begin
                plen0.push_back(cur_len0); cur_len0 = 0; in_pkt0 = 0; low_run0 = 0;
            end
            low_run0++;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) begin
            for (int i = 0; i < cur_len1; i++) dq1.delete(dq1.size() - 1);
            if (in_pkt1) begin
                rise_q1.delete(rise_q1.size() - 1);
                gap_q1.delete(gap_q1.size() - 1);
            end
            cur_len1 = 0; in_pkt1 = 0; low_run1 = 0;
        end else if (axiov1) begin
            if (!in_pkt1) begin
                in_pkt1 = 1; rises1++;
                rise_q1.push_back(cyc); gap_q1.push_back(low_run1);
            end
            dq1.push_back(axiod1); cur_len1++;
        end else begin
            if (axiod1 !== 2'b00) bad_idle1++;
            if (in_pkt1) begin
                plen1.push_back(cur_len1); cur_len1 = 0; in_pkt1 = 0; low_run1 = 0;
            end
            low_run1++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives tx_q as one packet followed by 'idle' low cycles; e is the edge that samples the first low.
    task automatic send_pkt(input int d, input int idle, output int e);
        foreach (tx_q[i]) begin
            @(negedge clk);
            if (d == 0) begin valid_in0 = 1'b1; byte_in0 = tx_q[i]; end
            else        begin valid_in1 = 1'b1; byte_in1 = tx_q[i]; end
        end
        @(negedge clk);
        if (d == 0) begin valid_in0 = 1'b0; byte_in0 = 8'($urandom); end
        else        begin valid_in1 = 1'b0; byte_in1 = 8'($urandom); end
        e = cyc + 1;
        repeat (idle - 1) @(negedge clk);
    endtask

    // Waits for the next output packet of DUT d and compares it byte by byte against exp_q.
    task automatic get_pkt(input int d, input string tag, output int rise, output int gap);
        int t = 0;
        int len;
        bit arrived;
        logic [1:0] dib;
        logic [7:0] b;
        logic [7:0] got[$];
        while (((d == 0) ? plen0.size() : plen1.size()) == 0 && t < 6000) begin
            @(negedge clk);
            t++;
        end
        arrived = ((d == 0) ? plen0.size() : plen1.size()) != 0;
        check({tag, "_arrived"}, 32'(arrived), 32'd1);
        rise = -1;
        gap = -1;
        if (arrived) begin
            if (d == 0) begin len = plen0.pop_front(); rise = rise_q0.pop_front(); gap = gap_q0.pop_front(); end
            else        begin len = plen1.pop_front(); rise = rise_q1.pop_front(); gap = gap_q1.pop_front(); end
            check({tag, "_len"}, 32'(len), 32'(4 * exp_q.size()));
            b = '0;
            for (int i = 0; i < len; i++) begin
                dib = (d == 0) ? dq0.pop_front() : dq1.pop_front();
                b[2 * (i % 4) +: 2] = dib;
                if (i % 4 == 3) got.push_back(b);
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                check($sformatf("%s_byte%0d", tag, i), 32'(got[i]), 32'(exp_q[i]));
            end
        end
    endtask

    int e, rise, gap, r0, n, keep, t;
    int mdl_len[$];
    logic [7:0] mdl_bytes[$];
    int idles[$];

    initial begin
        rst = 1'b1;
        valid_in0 = 1'b0; valid_in1 = 1'b0;
        byte_in0 = 8'h00; byte_in1 = 8'h00;
        repeat (2) @(negedge clk);
        check("reset_axiov0", 32'(axiov0), 32'd0);
        check("reset_axiod0", 32'(axiod0), 32'd0);
        check("reset_axiov1", 32'(axiov1), 32'd0);
        check("reset_axiod1", 32'(axiod1), 32'd0);
        rst = 1'b0;

        // valid_in held low while byte_in toggles
        repeat (20) begin
            @(negedge clk);
            byte_in0 = 8'($urandom);
        end
        repeat (60) @(negedge clk);
        check("no_valid_no_output", 32'(rises0), 32'd0);

        // single-cycle packet and its latency
        tx_q = '{8'h1B};
        send_pkt(0, 1, e);
        exp_q = '{8'h1B};
        get_pkt(0, "single", rise, gap);
        check("single_latency", 32'(rise), 32'(e + 2));

        // packet A, one idle cycle, packet B: gap must be exactly the IPG
        tx_q = '{8'h00, 8'hFF, 8'hE4};
        send_pkt(0, 1, e);
        tx_q = '{8'h55, 8'hAA};
        send_pkt(0, 1, e);
        exp_q = '{8'h00, 8'hFF, 8'hE4};
        get_pkt(0, "pkt_a", rise, gap);
        exp_q = '{8'h55, 8'hAA};
        get_pkt(0, "pkt_b", rise, gap);
        check("ab_gap", 32'(gap), 32'd48);

        // random packets, back to back on the input
        for (int k = 0; k < 8; k++) begin
            n = $urandom_range(1, 16);
            mdl_len.push_back(n);
            tx_q = {};
            for (int i = 0; i < n; i++) begin
                tx_q.push_back(8'($urandom));
                mdl_bytes.push_back(tx_q[i]);
            end
            send_pkt(0, $urandom_range(1, 3), e);
        end
        for (int k = 0; k < 8; k++) begin
            n = mdl_len.pop_front();
            exp_q = {};
            for (int i = 0; i < n; i++) exp_q.push_back(mdl_bytes.pop_front());
            get_pkt(0, $sformatf("rand%0d", k), rise, gap);
            check($sformatf("rand%0d_gap_min", k), 32'(gap >= 48), 32'd1);
        end

        // reset in the middle of a 20-byte transmission
        tx_q = {};
        for (int i = 0; i < 20; i++) tx_q.push_back(8'hFF);
        r0 = rises0;
        send_pkt(0, 1, e);
        t = 0;
        while (rises0 == r0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (20) @(negedge clk);
        check("midtx_axiov_before", 32'(axiov0), 32'd1);
        check("midtx_axiod_before", 32'(axiod0), 32'd3);
        #1 rst = 1'b1;
        #1;
        check("midtx_axiov_reset", 32'(axiov0), 32'd0);
        check("midtx_axiod_reset", 32'(axiod0), 32'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        r0 = rises0;
        repeat (200) @(negedge clk);
        check("after_reset_quiet", 32'(rises0), 32'(r0));

        // overflow on the DEPTH=8 instance: packet truncated but terminated
        tx_q = {};
        for (int i = 1; i <= 12; i++) tx_q.push_back(8'(i));
        send_pkt(1, 1, e);
        keep = (tx_q.size() - 1 < 8 - 2) ? tx_q.size() - 1 : 8 - 2;
        exp_q = {};
        for (int i = 0; i < keep; i++) exp_q.push_back(tx_q[i]);
        exp_q.push_back(tx_q[tx_q.size() - 1]);
        get_pkt(1, "ovf", rise, gap);
        check("ovf_latency", 32'(rise), 32'(e + 2));
        tx_q = '{8'($urandom), 8'($urandom)};
        send_pkt(1, 1, e);
        exp_q = tx_q;
        get_pkt(1, "ovf_next", rise, gap);
        check("ovf_next_gap_min", 32'(gap >= 48), 32'd1);

        // 84 bytes of 0xD2, then output must stay quiet
        tx_q = {};
        for (int i = 0; i < 84; i++) tx_q.push_back(8'hD2);
        r0 = rises0;
        send_pkt(0, 1, e);
        exp_q = tx_q;
        get_pkt(0, "d2", rise, gap);
        check("d2_latency", 32'(rise), 32'(e + 2));
        repeat (300) @(negedge clk);
        check("d2_single_burst", 32'(rises0), 32'(r0 + 1));

        check("idle_axiod0_zero", 32'(bad_idle0), 32'd0);
        check("idle_axiod1_zero", 32'(bad_idle1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
